// File: rtl/coeff_decomposer_pipe.sv
// coeff_decomposer_pipe
//   Splits each of LANES coefficients into a high part r1 (doa) and a low
//   part r0 (dob, stored mod q in [0,q)). Per beat, mode selects Dilithium
//   Decompose (gamma2 picked by sec_lvl) or Power2Round (d = 13).
//   An accepted beat is captured into an input register, then passes three
//   stages: mod-q reduction, quotient estimate, correction/output. Every
//   register advances on a common enable, so the pipe is fully stallable.
// Ports
//   clk, rst        clock / synchronous active-low reset
//   sec_lvl, mode   per-beat controls, travel with the beat
//   valid_i/ready_i input handshake
//   di              LANES x COEFF_W input coefficients
//   doa, dob        LANES x COEFF_W r1 / r0 results
//   valid_o/ready_o output handshake
// COEFF_W must be at least 24; only the low 24 input bits are used.

// Per-lane datapath. Controls for the beat in stage 1 / stage 2 come from the
// shared control pipe in the top level.
module coeff_decomposer_lane #(
  parameter int COEFF_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COEFF_W-1:0] di,
  input  logic               mode_s1,
  input  logic               sec_s1,
  input  logic               mode_s2,
  input  logic               sec_s2,
  output logic [COEFF_W-1:0] doa,
  output logic [COEFF_W-1:0] dob
);
  localparam logic [23:0] Q  = 24'd8380417;
  localparam logic [23:0] Q2 = 24'd16760834;

  logic [23:0]        din_q, din_d;
  logic [22:0]        rp_q, rp_d, rp2_q, rp2_d;
  logic [14:0]        x_q, x_d, x_b;
  logic [10:0]        e_q, e_d, e_b;
  logic [COEFF_W-1:0] doa_q, doa_d, dob_q, dob_d;
  logic [23:0]        t, r0e;
  logic [28:0]        prod;
  logic [25:0]        ed, rem, m;
  logic [14:0]        dv;
  logic [19:0]        dfull;
  logic [10:0]        r1;
  logic               corr, wrap;

  // Input capture and mod-q reduction: a 24-bit value is below 3q, so at most
  // two subtractions are needed.
  always_comb begin
    din_d = en ? di[23:0] : din_q;
    rp_d  = rp_q;
    if (en) begin
      if (din_q >= Q2)     rp_d = 23'(din_q - Q2);
      else if (din_q >= Q) rp_d = 23'(din_q - Q);
      else                 rp_d = din_q[22:0];
    end
  end

  // Quotient estimate. r1 = floor((r+ + half - 1) / D), which rounds ties
  // down so r0 lands in (-half, half]. Both 2*gamma2 values are 2^s * c with
  // c*M = 2^20 - 1 (93*11275, 1023*1025), so (x*M)>>20 is floor(x/c) or one
  // less; stage 3 fixes the shortfall. Power2Round divides by a shift only.
  always_comb begin
    t    = {1'b0, rp_q} + (mode_s1 ? 24'd4095 : (sec_s1 ? 24'd95231 : 24'd261887));
    if (mode_s1)     x_b = {4'b0, t[23:13]};
    else if (sec_s1) x_b = {2'b0, t[23:11]};
    else             x_b = t[23:9];
    prod  = 29'(x_b) * 29'(sec_s1 ? 14'd11275 : 14'd1025);
    e_b   = mode_s1 ? x_b[10:0] : {2'b0, prod[28:20]};
    rp2_d = en ? rp_q : rp2_q;
    x_d   = en ? x_b  : x_q;
    e_d   = en ? e_b  : e_q;
  end

  // Correction, q-1 wrap handling and r0 encoding.
  always_comb begin
    dv    = sec_s2 ? 15'd93 : 15'd1023;
    ed    = 26'(e_q) * 26'(dv);
    rem   = 26'(x_q) - ed;
    corr  = !mode_s2 && (rem >= 26'(dv));
    r1    = e_q + 11'(corr);
    dfull = mode_s2 ? 20'd8192 : (sec_s2 ? 20'd190464 : 20'd523776);
    m     = 26'(r1) * 26'(dfull);
    // r+ - r0 = q-1 happens exactly when r1 hits (q-1)/2gamma2; then
    // r0 - 1 = r+ - q, whose mod-q encoding is r+ itself.
    wrap  = !mode_s2 && (r1 == (sec_s2 ? 11'd44 : 11'd16));
    if (wrap)                   r0e = {1'b0, rp2_q};
    else if (m > 26'(rp2_q))    r0e = 24'(26'(rp2_q) + 26'(Q) - m);
    else                        r0e = 24'(26'(rp2_q) - m);
    doa_d = doa_q;
    dob_d = dob_q;
    if (en) begin
      doa_d = wrap ? '0 : COEFF_W'(r1);
      dob_d = COEFF_W'(r0e);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      din_q <= '0;
      rp_q  <= '0;
      rp2_q <= '0;
      x_q   <= '0;
      e_q   <= '0;
      doa_q <= '0;
      dob_q <= '0;
    end else begin
      din_q <= din_d;
      rp_q  <= rp_d;
      rp2_q <= rp2_d;
      x_q   <= x_d;
      e_q   <= e_d;
      doa_q <= doa_d;
      dob_q <= dob_d;
    end
  end

  assign doa = doa_q;
  assign dob = dob_q;
endmodule

module coeff_decomposer_pipe #(
  parameter int LANES   = 4,
  parameter int COEFF_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               sec_lvl,
  input  logic                     mode,
  input  logic                     valid_i,
  output logic                     ready_i,
  input  logic [LANES*COEFF_W-1:0] di,
  output logic [LANES*COEFF_W-1:0] doa,
  output logic [LANES*COEFF_W-1:0] dob,
  output logic                     valid_o,
  input  logic                     ready_o
);
  localparam int STAGES = 3;

  // vld_pipe[0] is the input capture register, [STAGES] drives valid_o.
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;
  logic [STAGES-1:0] mode_pipe_q, mode_pipe_d, sec_pipe_q, sec_pipe_d;
  logic              en;

  assign en      = ready_o | ~vld_pipe_q[STAGES];
  assign ready_i = en & rst;
  assign valid_o = vld_pipe_q[STAGES];

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    mode_pipe_d = mode_pipe_q;
    sec_pipe_d  = sec_pipe_q;
    if (en) begin
      vld_pipe_d  = {vld_pipe_q[STAGES-1:0], valid_i & ready_i};
      mode_pipe_d = {mode_pipe_q[STAGES-2:0], mode};
      sec_pipe_d  = {sec_pipe_q[STAGES-2:0], sec_lvl == 3'b010};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe_q  <= '0;
      mode_pipe_q <= '0;
      sec_pipe_q  <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      mode_pipe_q <= mode_pipe_d;
      sec_pipe_q  <= sec_pipe_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    coeff_decomposer_lane #(.COEFF_W(COEFF_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .di      (di[k*COEFF_W +: COEFF_W]),
      .mode_s1 (mode_pipe_q[1]),
      .sec_s1  (sec_pipe_q[1]),
      .mode_s2 (mode_pipe_q[2]),
      .sec_s2  (sec_pipe_q[2]),
      .doa     (doa[k*COEFF_W +: COEFF_W]),
      .dob     (dob[k*COEFF_W +: COEFF_W])
    );
  end
endmodule

// File: tb/tb_coeff_decomposer_pipe.sv
// Bench for coeff_decomposer_pipe: directed literal vectors, a back-to-back
// mixed-mode stream, a backpressure window and a mid-stream reset. A
// scoreboard of beats expected from an arithmetic model is checked against
// every output beat.
module tb_coeff_decomposer_pipe;
  localparam int     LANES = 4;
  localparam int     W     = 24;
  localparam longint Q     = 8380417;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [2:0]         sec_lvl = 3'b010;
  logic               mode = 1'b0;
  logic               valid_i = 1'b0;
  logic               ready_o = 1'b1;
  logic               ready_i, valid_o;
  logic [LANES*W-1:0] di = '0;
  logic [LANES*W-1:0] doa, dob;

  always #5 clk = ~clk;

  coeff_decomposer_pipe #(.LANES(LANES), .COEFF_W(W)) dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .mode(mode), .valid_i(valid_i),
    .ready_i(ready_i), .di(di), .doa(doa), .dob(dob), .valid_o(valid_o),
    .ready_o(ready_o)
  );

  int total = 0, bad = 0, cyc = 0, n_out = 0;
  bit lat_chk = 1'b1;

  typedef struct {
    logic [LANES*W-1:0] a;
    logic [LANES*W-1:0] b;
    int                 acc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [LANES*W-1:0] act,
                     input logic [LANES*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Straight from the definitions: centred remainder, then the q-1 special case.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] d, input bit m,
                                           input bit s010);
    longint rp, r0, r1, g2, dob_v;
    rp = longint'(d) % Q;
    if (m) begin
      r0 = rp % 8192;
      if (r0 > 4096) r0 -= 8192;
      r1 = (rp - r0) / 8192;
    end else begin
      g2 = s010 ? 95232 : 261888;
      r0 = rp % (2 * g2);
      if (r0 > g2) r0 -= 2 * g2;
      if (rp - r0 == Q - 1) begin
        r1 = 0;
        r0 = r0 - 1;
      end else begin
        r1 = (rp - r0) / (2 * g2);
      end
    end
    dob_v = (r0 < 0) ? Q + r0 : r0;
    return {W'(r1), W'(dob_v)};
  endfunction

  // Beat acceptance is decided half a cycle before the edge from stable values.
  bit                 pend = 1'b0;
  logic [LANES*W-1:0] pend_di;
  logic               pend_m;
  logic [2:0]         pend_s;

  always @(posedge clk) begin
    exp_t           e;
    logic [2*W-1:0] r;
    cyc = cyc + 1;
    if (!rst) begin
      sbq.delete();
    end else if (pend) begin
      for (int k = 0; k < LANES; k++) begin
        r = model(pend_di[k*W +: W], pend_m, pend_s == 3'b010);
        e.a[k*W +: W] = r[2*W-1:W];
        e.b[k*W +: W] = r[W-1:0];
      end
      e.acc = cyc;
      sbq.push_back(e);
    end
  end

  // Compare process.
  bit                 prev_stall = 1'b0;
  logic [LANES*W-1:0] prev_a, prev_b;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (prev_stall && rst) begin
      chk("stall_valid_o", valid_o, 1);
      chk("stall_doa", doa, prev_a);
      chk("stall_dob", dob, prev_b);
    end
    if (valid_o && !ready_o) chk("stall_ready_i", ready_i, 0);
    if (valid_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_beat", valid_o, 0);
      end else begin
        e = sbq[0];
        chk("sb_doa", doa, e.a);
        chk("sb_dob", dob, e.b);
        if (lat_chk) chk("latency", cyc - e.acc, 3);
        if (ready_o) begin
          void'(sbq.pop_front());
          n_out++;
        end
      end
    end
    prev_stall = valid_o && !ready_o;
    prev_a     = doa;
    prev_b     = dob;
    pend       = rst && valid_i && ready_i;
    pend_di    = di;
    pend_m     = mode;
    pend_s     = sec_lvl;
  end

  // One beat, all lanes equal, with a hand-computed literal expectation.
  task automatic dir(input string nm, input logic [W-1:0] v, input logic m,
                     input logic [2:0] s, input int r1, input int d0);
    logic [W-1:0] ea, eb;
    bit got;
    ea = W'(r1);
    eb = W'(d0);
    @(negedge clk);
    di = {LANES{v}}; mode = m; sec_lvl = s; valid_i = 1'b1; ready_o = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      #3;
      if (valid_o) got = 1'b1;
    end
    if (!got) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_doa"}, doa, {LANES{ea}});
      chk({nm, "_dob"}, dob, {LANES{eb}});
    end
  endtask

  task automatic rand_beat(input int i);
    for (int k = 0; k < LANES; k++) di[k*W +: W] = W'($urandom_range(0, 24'hFFFFFF));
    if (i == 0) di[W-1:0] = 24'hFFFFFF;
    if (i == 1) di[W-1:0] = 24'd8380416;
    mode    = i[0] ^ (i > 4);
    sec_lvl = (i % 3 == 0) ? 3'b010 : ((i % 3 == 1) ? 3'b101 : 3'b000);
  endtask

  initial begin
    int n0, sent;
    // Reset state
    repeat (2) @(negedge clk);
    #3;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_i", ready_i, 0);
    chk("rst_doa", doa, '0);
    chk("rst_dob", dob, '0);
    @(negedge clk);
    rst = 1'b1;

    // Directed literals
    dir("dec2_0",       24'd0,        1'b0, 3'b010, 0, 0);
    dir("dec2_95232",   24'd95232,    1'b0, 3'b010, 0, 95232);
    dir("dec2_95233",   24'd95233,    1'b0, 3'b010, 1, 8285186);
    dir("dec2_wrap",    24'd8380416,  1'b0, 3'b010, 0, 8380416);
    dir("dec5_261889",  24'd261889,   1'b0, 3'b101, 1, 8118530);
    dir("dec5_523776",  24'd523776,   1'b0, 3'b101, 1, 0);
    dir("dec5_q",       24'd8380417,  1'b0, 3'b101, 0, 0);
    dir("p2r_4096",     24'd4096,     1'b1, 3'b010, 0, 4096);
    dir("p2r_4097",     24'd4097,     1'b1, 3'b101, 1, 8376322);
    dir("p2r_max",      24'hFFFFFF,   1'b1, 3'b000, 2, 8380414);

    // Back-to-back stream, mixed modes
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rand_beat(i);
      valid_i = 1'b1;
    end
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #5;
    chk("stream_count", n_out - n0, 8);

    // Backpressure: ready_o low for 4 cycles mid-stream
    lat_chk = 1'b0;
    n0 = n_out;
    sent = 0;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      @(negedge clk);
      ready_o = !(c >= 5 && c < 9);
      rand_beat(c + 3);
      valid_i = 1'b1;
      #1;
      if (ready_i) sent++;
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_o = 1'b1;
    for (int c = 0; c < 20 && sbq.size() != 0; c++) @(negedge clk);
    #5;
    chk("bp_count", n_out - n0, 10);
    lat_chk = 1'b1;

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_beat(i);
      valid_i = 1'b1;
    end
    @(negedge clk);
    valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_ready_i", ready_i, 0);
    n0 = n_out;
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("midrst_valid_o", valid_o, 0);
    chk("midrst_doa", doa, '0);
    chk("midrst_dob", dob, '0);
    repeat (6) @(negedge clk);
    #3;
    chk("midrst_no_stale", n_out - n0, 0);
    dir("post_rst_p2r", 24'd4097, 1'b1, 3'b010, 1, 8376322);

    for (int c = 0; c < 30 && sbq.size() != 0; c++) @(negedge clk);
    chk("drain_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
